// File: rtl/stream_select_mux_if.sv
// Stream bundle between N producer channels, the selector, and one consumer.
// The mux itself uses the slave modport; the master modport is the producer/consumer side.
interface stream_select_mux_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ADDR_BITS = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic [ADDR_BITS-1:0]      out_channel;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_channel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_channel
  );
endinterface

// File: rtl/stream_select_mux.sv
// N-channel registered stream selector: addressed select or round-robin arbitration
// feeding a single one-beat output register with valid/ready flow control.
module stream_select_mux #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [ADDR_BITS-1:0] address,
  stream_select_mux_if.slave   bus
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0][WIDTH-1:0] chan_data;
  logic                           can_accept;
  logic                           rr_found;
  logic [ADDR_BITS-1:0]           rr_grant;
  int unsigned                    rr_idx;
  logic [ADDR_BITS-1:0]           grant;
  logic                           grant_ok;
  logic [CHANNELS-1:0]            ready_vec;
  logic                           in_xfer;

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADDR_BITS-1:0] out_channel_q, out_channel_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;

  assign chan_data = bus.in_data;

  // First valid channel at or after ptr; ptr always stays below CHANNELS.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_idx   = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rr_idx = (32'(ptr_q) + i) % CHANNELS;
      if (!rr_found && bus.in_valid[SEL_W'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_grant = ADDR_BITS'(rr_idx);
      end
    end
  end

  // Ready generation; addressed mode offers ready regardless of in_valid.
  always_comb begin
    can_accept = !out_valid_q || bus.out_ready;
    ready_vec  = '0;
    grant      = '0;
    grant_ok   = 1'b0;
    if (mode) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = address;
      grant_ok = (32'(address) < CHANNELS);
    end
    if (grant_ok && can_accept) ready_vec[SEL_W'(grant)] = 1'b1;
    if (reset) ready_vec = '0;
    in_xfer = |(ready_vec & bus.in_valid);
  end

  assign bus.in_ready = ready_vec;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    ptr_d         = ptr_q;
    if (in_xfer) begin
      out_valid_d   = 1'b1;
      out_data_d    = chan_data[SEL_W'(grant)];
      out_channel_d = grant;
      if (mode) ptr_d = ADDR_BITS'((32'(grant) + 32'd1) % CHANNELS);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      ptr_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      ptr_q         <= ptr_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
endmodule

// File: tb/tb_stream_select_mux.sv
// Bench for stream_select_mux: a 4-channel and a 3-channel instance, driven in turn,
// with a queue-based reference model and a decoupled output monitor.
module tb_stream_select_mux;
  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT stimulus/observation arrays: index 0 = 4 channels, index 1 = 3 channels.
  logic [3:0]  iv [2];
  logic [31:0] id [2];
  logic        ordy [2];
  logic        md [2];
  logic [1:0]  ad [2];
  logic [3:0]  ir [2];
  logic [7:0]  od [2];
  logic        ov [2];
  logic [1:0]  oc [2];

  stream_select_mux_if #(.WIDTH(8), .CHANNELS(4), .ADDR_BITS(2)) bus4 ();
  stream_select_mux_if #(.WIDTH(8), .CHANNELS(3), .ADDR_BITS(2)) bus3 ();

  stream_select_mux #(.WIDTH(8), .CHANNELS(4), .ADDR_BITS(2)) dut4 (
    .clk(clk), .reset(reset), .mode(md[0]), .address(ad[0]), .bus(bus4)
  );
  stream_select_mux #(.WIDTH(8), .CHANNELS(3), .ADDR_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .mode(md[1]), .address(ad[1]), .bus(bus3)
  );

  assign bus4.in_valid  = iv[0];
  assign bus4.in_data   = id[0];
  assign bus4.out_ready = ordy[0];
  assign ir[0] = bus4.in_ready;
  assign od[0] = bus4.out_data;
  assign ov[0] = bus4.out_valid;
  assign oc[0] = bus4.out_channel;

  assign bus3.in_valid  = iv[1][2:0];
  assign bus3.in_data   = id[1][23:0];
  assign bus3.out_ready = ordy[1];
  assign ir[1] = {1'b0, bus3.in_ready};
  assign od[1] = bus3.out_data;
  assign ov[1] = bus3.out_valid;
  assign oc[1] = bus3.out_channel;

  // Reference model state: pending producer beats, priority pointer, output occupancy.
  int    cur = 0;
  int    nch = 4;
  int    m_ptr [2];
  bit    m_occ [2];
  bit    pv [2][4];
  logic [7:0] pd [2][4];
  beat_t exp_q [$];
  int    seen_ch [$];
  int    seen_d [$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", name, act, exp, cur, $time);
    end
  endtask

  task automatic chk_seen(input string name, input int idx, input int exp, input bit use_data);
    int act;
    act = -1;
    if (use_data) begin
      if (idx < seen_d.size()) act = seen_d[idx];
    end else if (idx < seen_ch.size()) begin
      act = seen_ch[idx];
    end
    chk(name, act, exp);
  endtask

  // One clock of stimulus: refill idle producers in vmask, drive, check ready/valid, advance model.
  task automatic step(input logic m, input logic [1:0] a, input logic ordy_i,
                      input logic [3:0] vmask, input bit fixed);
    int g;
    int k;
    bit can;
    bit in_x;
    logic [3:0] exp_rdy;
    beat_t b;
    @(negedge clk);
    for (int c = 0; c < nch; c++) begin
      if (!pv[cur][c] && vmask[c]) begin
        pv[cur][c] = 1'b1;
        pd[cur][c] = fixed ? 8'(8'h11 * (c + 1)) : 8'($urandom);
      end
    end
    iv[cur] = '0;
    id[cur] = '0;
    for (int c = 0; c < nch; c++) begin
      iv[cur][c] = pv[cur][c];
      id[cur][c*8 +: 8] = pd[cur][c];
    end
    md[cur] = m;
    ad[cur] = a;
    ordy[cur] = ordy_i;
    #1;
    can = !m_occ[cur] || ordy_i;
    g = -1;
    exp_rdy = '0;
    if (m) begin
      for (int i = 0; i < nch; i++) begin
        k = (m_ptr[cur] + i) % nch;
        if (g < 0 && pv[cur][k]) g = k;
      end
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
    end else if (int'(a) < nch) begin
      if (can) exp_rdy[a] = 1'b1;
      if (pv[cur][a]) g = int'(a);
    end
    in_x = can && (g >= 0);
    chk("in_ready", 32'(ir[cur]), 32'(exp_rdy));
    chk("out_valid", 32'(ov[cur]), 32'(m_occ[cur]));
    if (in_x) begin
      b.d = pd[cur][g];
      b.ch = 2'(g);
      exp_q.push_back(b);
      pv[cur][g] = 1'b0;
      if (m) m_ptr[cur] = (g + 1) % nch;
    end
    m_occ[cur] = in_x ? 1'b1 : ((m_occ[cur] && ordy_i) ? 1'b0 : m_occ[cur]);
  endtask

  // Reset asserted in the low phase, checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    iv[cur] = '0;
    md[cur] = 1'b0;
    ad[cur] = 2'd0;
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ov[cur]), 32'd0);
    chk("rst_out_data", 32'(od[cur]), 32'd0);
    chk("rst_out_channel", 32'(oc[cur]), 32'd0);
    chk("rst_in_ready", 32'(ir[cur]), 32'd0);
    m_occ[cur] = 1'b0;
    m_ptr[cur] = 0;
    exp_q.delete();
    #2 reset = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < nch + 3; i++) step(1'b1, 2'd0, 1'b1, 4'h0, 1'b0);
  endtask

  task automatic rand_phase(input int n);
    logic m;
    m = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) m = ~m;
      step(m, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), 4'($urandom), 1'b0);
    end
  endtask

  // Monitor: whenever a beat is presented, compare it with the oldest expected beat.
  always @(negedge clk) begin
    #3;
    if (!reset && ov[cur]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_spurious: beat %0h ch %0d presented with nothing expected", od[cur], oc[cur]);
      end else begin
        chk("out_data", 32'(od[cur]), 32'(exp_q[0].d));
        chk("out_channel", 32'(oc[cur]), 32'(exp_q[0].ch));
        if (ordy[cur]) begin
          seen_ch.push_back(int'(oc[cur]));
          seen_d.push_back(int'(od[cur]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = '0; id[d] = '0; ordy[d] = 1'b0; md[d] = 1'b0; ad[d] = '0;
      m_ptr[d] = 0; m_occ[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin pv[d][c] = 1'b0; pd[d][c] = '0; end
    end
    #2 reset = 1'b1;
    #1;
    chk("init_out_valid", 32'(ov[0]), 32'd0);
    chk("init_in_ready", 32'(ir[0]), 32'd0);
    #9 reset = 1'b0;

    // Addressed sweep with fixed channel data.
    seen_ch.delete(); seen_d.delete();
    for (int a = 0; a < 4; a++) step(1'b0, 2'(a), 1'b1, 4'hF, 1'b1);
    flush();
    for (int i = 0; i < 4; i++) begin
      chk_seen("sweep_data", i, 8'h11 * (i + 1), 1'b1);
      chk_seen("sweep_channel", i, i, 1'b0);
    end

    // Backpressure holding 0xA5, then same-edge reload on release.
    pv[0][0] = 1'b1; pd[0][0] = 8'hA5;
    step(1'b0, 2'd0, 1'b1, 4'h0, 1'b0);
    repeat (3) step(1'b0, 2'd0, 1'b0, 4'hF, 1'b0);
    chk("bp_hold_data", 32'(od[0]), 32'hA5);
    step(1'b0, 2'd1, 1'b1, 4'hF, 1'b0);
    step(1'b0, 2'd2, 1'b1, 4'hF, 1'b0);
    step(1'b0, 2'd2, 1'b0, 4'hF, 1'b0);
    chk("pre_reset_valid", 32'(ov[0]), 32'd1);
    do_reset();

    // Round-robin fairness from ptr=0.
    seen_ch.delete(); seen_d.delete();
    repeat (6) step(1'b1, 2'd0, 1'b1, 4'hF, 1'b0);
    flush();
    for (int i = 0; i < 6; i++) chk_seen("rr_fair_channel", i, i % 4, 1'b0);

    // Sparse round-robin: channels 1 and 3 only.
    do_reset();
    seen_ch.delete(); seen_d.delete();
    repeat (4) step(1'b1, 2'd0, 1'b1, 4'b1010, 1'b0);
    flush();
    for (int i = 0; i < 4; i++) chk_seen("rr_sparse_channel", i, (i % 2 == 0) ? 1 : 3, 1'b0);

    rand_phase(300);
    flush();

    // Three-channel instance: out-of-range address, then wrap at 3.
    cur = 1; nch = 3;
    do_reset();
    seen_ch.delete(); seen_d.delete();
    repeat (3) step(1'b0, 2'd3, 1'b1, 4'h7, 1'b0);
    #3;
    chk("c3_oob_no_output", seen_ch.size(), 0);
    repeat (4) step(1'b1, 2'd0, 1'b1, 4'h7, 1'b0);
    flush();
    for (int i = 0; i < 4; i++) chk_seen("c3_rr_channel", i, i % 3, 1'b0);

    rand_phase(300);
    flush();
    @(negedge clk);
    #4;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
